serial_sub: RTL and testbench
=============================

SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 Parameter: WIDTH, default 4, operand and result width in bits (legal 2..16).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request; sampled each rising edge.
REQ-005 a  input  WIDTH  minuend; captured on an accepted start.
REQ-006 b  input  WIDTH  subtrahend; captured on an accepted start.
REQ-007 bin  input  1  borrow-in; captured on an accepted start.
REQ-008 busy  output  1  high while a subtraction is in progress.
REQ-009 done  output  1  one-cycle pulse: result valid.
REQ-010 diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH.
REQ-011 bout  output  1  borrow-out; high when a < b + bin (unsigned).

Function
REQ-012 The block SHALL be a bit-serial ripple-borrow subtractor: one bit per clock, LSB first, borrow carried in a flip-flop.
REQ-013 FSM states SHALL be IDLE, SHIFT, DONE.
REQ-014 IDLE: start=1 at an edge SHALL capture a, b, bin, clear the bit counter, and go to SHIFT; start=0 SHALL stay in IDLE.
REQ-015 SHIFT, bit i: d_i = a_i ^ b_i ^ brw, and brw_next = (~a_i & b_i) | (~(a_i ^ b_i) & brw), with brw initialised to captured bin.
REQ-016 SHIFT SHALL last exactly WIDTH cycles; the edge processing bit WIDTH-1 SHALL go to DONE.
REQ-017 busy SHALL be 1 in SHIFT and 0 in IDLE and DONE.
REQ-018 done SHALL be 1 for exactly the one cycle in DONE.
REQ-019 diff and bout SHALL update only on DONE entry and hold until the next DONE entry or reset.
REQ-020 Latency: start sampled at edge k SHALL give done=1 during the cycle after edge k+WIDTH.
REQ-021 DONE: start=1 SHALL capture new operands and go to SHIFT, allowing back-to-back operation; start=0 SHALL go to IDLE.
REQ-022 start in SHIFT SHALL be ignored; captured operands SHALL not change mid-operation.
REQ-023 Changes on a, b, or bin after capture SHALL not affect the result.
REQ-024 Wrap-around: results SHALL be modulo 2^WIDTH, with the borrow reported only on bout.

Reset
REQ-025 While rst=1, the state SHALL be IDLE and busy, done, diff, bout, the counter, and internal registers SHALL all be 0, regardless of clk.
REQ-026 Reset asserted mid-SHIFT SHALL abort the operation, with no done pulse and no result update.
REQ-027 After rst deasserts, the first rising edge with start=1 SHALL be accepted normally.

Configuration
REQ-028 Macro SERIAL_SUB_OVF_EN SHALL control the signed-overflow feature.
REQ-029 With SERIAL_SUB_OVF_EN defined:
- extra output port ovf, output, 1 bit.
- ovf = (a_msb != b_msb) & (d_msb != a_msb), i.e. two's-complement overflow of a - b - bin.
- ovf updates and holds with diff, and is reset to 0.
REQ-030 With SERIAL_SUB_OVF_EN undefined:
- port ovf and its logic SHALL be absent.
- all other behaviour SHALL be identical.

Verification (WIDTH=4)
REQ-031 a=9, b=3, bin=0, start pulse -> busy 4 cycles, then done; diff=6, bout=0.
REQ-032 a=3, b=9, bin=0 -> diff=0xA, bout=1; a=0, b=0, bin=1 -> diff=0xF, bout=1.
REQ-033 Back-to-back: start held high through DONE with a=15, b=15, bin=0 -> second done exactly 5 cycles after the first; diff=0, bout=0.
REQ-034 start pulsed and a/b toggled during SHIFT -> no restart; result matches originally captured operands; single done.
REQ-035 rst asserted after 2 SHIFT cycles -> all outputs 0 immediately (asynchronous); no done; next start with a=5, b=2 -> diff=3.
REQ-036 With SERIAL_SUB_OVF_EN: a=8, b=1, bin=0 -> diff=7, ovf=1; a=5, b=2 -> ovf=0.

Source files
------------

// File: rtl/serial_sub.sv
// serial_sub: bit-serial ripple-borrow subtractor computing a - b - bin.
// One result bit per clock, LSB first, with the borrow held in a flop.
// Optional feature macro: SERIAL_SUB_OVF_EN adds the signed-overflow output ovf.
//
// Handshake: start is sampled on every rising edge. It is accepted in IDLE
// and DONE and ignored in SHIFT. busy is high for the WIDTH cycles of SHIFT.
// done pulses for one cycle, and diff/bout (and ovf) are valid from that
// cycle until the next DONE entry.
module serial_sub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Current bit of the ripple-borrow subtractor; operands shift right so bit 0 is the live bit.
  logic d_bit;
  logic brw_nx;
  logic last_bit;

  assign d_bit    = a_q[0] ^ b_q[0] ^ brw_q;
  assign brw_nx   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & brw_q);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  // State and datapath registers, all cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Next-state and datapath update: capture in IDLE/DONE, one bit per cycle in SHIFT.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SHIFT;
          a_d     = a;
          b_d     = b;
          brw_d   = bin;
          acc_d   = '0;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        acc_d = {d_bit, acc_q[WIDTH-1:1]};
        brw_d = brw_nx;
        cnt_d = cnt_q + CW'(1);
        if (last_bit) begin
          // Bit 0 of a_q/b_q now holds the operand MSBs; publish the result.
          state_d = DONE;
          diff_d  = {d_bit, acc_q[WIDTH-1:1]};
          bout_d  = brw_nx;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = (a_q[0] != b_q[0]) & (d_bit != a_q[0]);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// Testbench for serial_sub (WIDTH=4): directed cases plus randomized
// operations checked against an arithmetic reference model.
module tb_serial_sub;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         bin_in;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int checks;
  int failures;

  serial_sub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a_in),
    .b     (b_in),
    .bin   (bin_in),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operands.
  function automatic logic [W-1:0] ref_diff(input int a, input int b, input int bi);
    int r;
    r = a - b - bi;
    return W'(r & ((1 << W) - 1));
  endfunction

  function automatic logic ref_bout(input int a, input int b, input int bi);
    return (a < b + bi);
  endfunction

  function automatic logic ref_ovf(input int a, input int b, input int bi);
    int sa, sb, r;
    sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
    sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
    r  = sa - sb - bi;
    return (r < -(1 << (W - 1))) || (r > (1 << (W - 1)) - 1);
  endfunction

  task automatic check_result(input string tag, input int a, input int b, input int bi);
    chk({tag, "_diff"}, 32'(diff), 32'(ref_diff(a, b, bi)));
    chk({tag, "_bout"}, 32'(bout), 32'(ref_bout(a, b, bi)));
`ifdef SERIAL_SUB_OVF_EN
    chk({tag, "_ovf"}, 32'(ovf), 32'(ref_ovf(a, b, bi)));
`endif
  endtask

  // One complete operation; with noise set, start and operands are churned during SHIFT.
  task automatic run_op(input string tag, input int a, input int b, input int bi, input bit noise);
    a_in   = W'(a);
    b_in   = W'(b);
    bin_in = bi[0];
    start  = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_nodone"}, 32'(done), 32'd0);
      if (noise) begin
        a_in   = W'($urandom);
        b_in   = W'($urandom);
        bin_in = 1'($urandom);
        start  = 1'($urandom_range(0, 1));
      end
      step();
    end
    start = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_off"}, 32'(busy), 32'd0);
    check_result(tag, a, b, bi);
    step();
    chk({tag, "_done_once"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    check_result({tag, "_hold"}, a, b, bi);
  endtask

  initial begin
    int ra, rb, rbi, gap;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    start    = 1'b0;
    a_in     = '0;
    b_in     = '0;
    bin_in   = 1'b0;

    // Reset state.
    step();
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif
    rst = 1'b0;
    step();

    // Directed basic cases.
    run_op("d_9m3", 9, 3, 0, 1'b0);
    run_op("d_3m9", 3, 9, 0, 1'b0);
    run_op("d_0m0b1", 0, 0, 1, 1'b0);
    run_op("d_8m1", 8, 1, 0, 1'b0);
    run_op("d_5m2", 5, 2, 0, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
    chk("ovf_5m2_direct", 32'(ovf), 32'd0);
`endif

    // Start and operands churned during SHIFT.
    run_op("noise_a", 12, 7, 1, 1'b1);
    run_op("noise_b", 2, 14, 0, 1'b1);

    // Back-to-back: start presented during DONE.
    a_in   = 4'd9;
    b_in   = 4'd3;
    bin_in = 1'b0;
    start  = 1'b1;
    step();
    start = 1'b0;
    repeat (W) step();
    chk("b2b_first_done", 32'(done), 32'd1);
    check_result("b2b_first", 9, 3, 0);
    a_in   = 4'd15;
    b_in   = 4'd15;
    bin_in = 1'b0;
    start  = 1'b1;
    step();
    start = 1'b0;
    chk("b2b_restart_busy", 32'(busy), 32'd1);
    for (int i = 0; i < W; i++) begin
      chk("b2b_gap_nodone", 32'(done), 32'd0);
      step();
    end
    chk("b2b_second_done", 32'(done), 32'd1);
    check_result("b2b_second", 15, 15, 0);
    step();

    // Reset in the middle of SHIFT: outputs clear at once, no done follows.
    a_in   = 4'd1;
    b_in   = 4'd2;
    bin_in = 1'b1;
    start  = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("mid_busy_pre", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_diff", 32'(diff), 32'd0);
    chk("mid_rst_bout", 32'(bout), 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      chk("mid_rst_nodone", 32'(done), 32'd0);
      step();
    end
    run_op("post_rst_5m2", 5, 2, 0, 1'b0);

    // Randomized operations with random idle gaps.
    for (int n = 0; n < 30; n++) begin
      ra  = int'($urandom_range(0, (1 << W) - 1));
      rb  = int'($urandom_range(0, (1 << W) - 1));
      rbi = int'($urandom_range(0, 1));
      run_op("rand", ra, rb, rbi, 1'($urandom_range(0, 1)));
      gap = int'($urandom_range(0, 2));
      repeat (gap) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
